// File: rtl/nxor_parity_scheduler_if.sv
// Request/response bundle between parity-checking clients and nxor_parity_scheduler.
// Requester k owns bit k of the per-requester vectors and req_data[k*N +: N].
interface nxor_parity_scheduler_if #(
    parameter int N   = 8,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) ();
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_last;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_data;
    logic [IDW-1:0] rsp_id;
    logic           rsp_ready;
    logic           busy;

    // Client side: drives beats, consumes responses.
    modport master (
        output req_valid, req_data, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_data, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/nxor_parity_scheduler.sv
// Round-robin scheduler sharing one XNOR reduction unit among R requesters.
// Each granted frame is folded into one even-parity bit returned with the requester id.

// Combinational N-bit XNOR reduction; MODEL picks the coding style, the function is identical.
module UnaryNXOR #(
    parameter string MODEL = "Structural",
    parameter int    N     = 8
) (
    input  logic [N-1:0] a,
    output logic         y
);
    if (MODEL == "Behavioral") begin : g_beh
        // Fold bits one at a time starting from the XNOR identity.
        always_comb begin
            y = 1'b1;
            for (int i = 0; i < N; i++) begin
                y = y ^ a[i];
            end
        end
    end else if (MODEL == "DataFlow") begin : g_df
        assign y = ~^a;
    end else begin : g_str
        // Ripple chain of two-input XOR stages, one net per stage.
        for (genvar i = 0; i < N; i++) begin : g_st
            logic s;
            if (i == 0) begin : g_first
                assign s = a[0];
            end else begin : g_next
                assign s = g_st[i-1].s ^ a[i];
            end
        end
        assign y = ~g_st[N-1].s;
    end
endmodule

module nxor_parity_scheduler #(
    parameter string MODEL = "Structural",
    parameter int    N     = 8,
    parameter int    R     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nxor_parity_scheduler_if.slave bus
);
    localparam int IDW = $clog2(R);

    typedef enum logic [1:0] {StIdle, StAccum, StResp} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           acc_q, acc_d;
    logic           rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;

    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;
    logic           found;
    logic [N-1:0]   beats [R];
    logic [N-1:0]   beat;
    logic           beat_nx;
    logic           frame_bit;

    for (genvar k = 0; k < R; k++) begin : g_slice
        assign beats[k] = bus.req_data[k*N +: N];
    end

    assign beat = beats[gnt_q];

    UnaryNXOR #(
        .MODEL (MODEL),
        .N     (N)
    ) u_nxor (
        .a (beat),
        .y (beat_nx)
    );

    // Running XOR parity including the beat currently presented.
    assign frame_bit = acc_q ^ ~beat_nx;

    // Round-robin pick: first valid requester searching upward from ptr, wrapping.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < R; i++) begin
            idx = IDW'((int'(ptr_q) + i) % R);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state logic; the grant is held for the whole frame regardless of other requests.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                acc_d = 1'b0;
                if (found) begin
                    gnt_d   = pick;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (bus.req_valid[gnt_q]) begin
                    if (bus.req_last[gnt_q]) begin
                        rsp_data_d = ~frame_bit;
                        rsp_id_d   = gnt_q;
                        state_d    = StResp;
                    end else begin
                        acc_d = frame_bit;
                    end
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    ptr_d   = IDW'((int'(gnt_q) + 1) % R);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            ptr_q      <= '0;
            acc_q      <= 1'b0;
            rsp_data_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // Handshake outputs decode from registered state only.
    assign bus.req_ready = (state_q == StAccum) ? (R'(1) << gnt_q) : '0;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_nxor_parity_scheduler.sv
// Bench for nxor_parity_scheduler: three DUTs (one per MODEL) share stimulus;
// directed scenarios followed by a randomized run against a frame-level reference model.
module tb_nxor_parity_scheduler;
    localparam int N   = 8;
    localparam int R   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [N-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           par;
    } rsp_t;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   req_last;
    logic           rsp_ready;

    int n_assert;
    int n_fail;
    int ptr_m;

    beat_t bq [R][$];
    bit    fpar [R][$];
    rsp_t  exp_q [$];

    nxor_parity_scheduler_if #(.N(N), .R(R)) bus0 ();
    nxor_parity_scheduler_if #(.N(N), .R(R)) bus1 ();
    nxor_parity_scheduler_if #(.N(N), .R(R)) bus2 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_data  = req_data;
    assign bus0.req_last  = req_last;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_data  = req_data;
    assign bus1.req_last  = req_last;
    assign bus1.rsp_ready = rsp_ready;
    assign bus2.req_valid = req_valid;
    assign bus2.req_data  = req_data;
    assign bus2.req_last  = req_last;
    assign bus2.rsp_ready = rsp_ready;

    nxor_parity_scheduler #(.MODEL("Structural"), .N(N), .R(R)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0)
    );
    nxor_parity_scheduler #(.MODEL("Behavioral"), .N(N), .R(R)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    nxor_parity_scheduler #(.MODEL("DataFlow"), .N(N), .R(R)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2)
    );

    logic [R-1:0]   o_rdy [3];
    logic           o_rv  [3];
    logic           o_rd  [3];
    logic [IDW-1:0] o_id  [3];
    logic           o_bz  [3];

    assign o_rdy[0] = bus0.req_ready;
    assign o_rv[0]  = bus0.rsp_valid;
    assign o_rd[0]  = bus0.rsp_data;
    assign o_id[0]  = bus0.rsp_id;
    assign o_bz[0]  = bus0.busy;
    assign o_rdy[1] = bus1.req_ready;
    assign o_rv[1]  = bus1.rsp_valid;
    assign o_rd[1]  = bus1.rsp_data;
    assign o_id[1]  = bus1.rsp_id;
    assign o_bz[1]  = bus1.busy;
    assign o_rdy[2] = bus2.req_ready;
    assign o_rv[2]  = bus2.rsp_valid;
    assign o_rd[2]  = bus2.rsp_data;
    assign o_id[2]  = bus2.rsp_id;
    assign o_bz[2]  = bus2.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [R-1:0] e_rdy, input logic e_rv,
                           input logic e_rd, input logic [IDW-1:0] e_id, input logic e_bz,
                           input bit with_rsp);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("%s/m%0d/req_ready", tag, m), 32'(o_rdy[m]), 32'(e_rdy));
            chk($sformatf("%s/m%0d/rsp_valid", tag, m), 32'(o_rv[m]), 32'(e_rv));
            chk($sformatf("%s/m%0d/busy", tag, m), 32'(o_bz[m]), 32'(e_bz));
            if (with_rsp) begin
                chk($sformatf("%s/m%0d/rsp_data", tag, m), 32'(o_rd[m]), 32'(e_rd));
                chk($sformatf("%s/m%0d/rsp_id", tag, m), 32'(o_id[m]), 32'(e_id));
            end
        end
    endtask

    task automatic chk_acc(input string tag, input logic e);
        chk({tag, "/m0/acc"}, 32'(u_dut0.acc_q), 32'(e));
        chk({tag, "/m1/acc"}, 32'(u_dut1.acc_q), 32'(e));
        chk({tag, "/m2/acc"}, 32'(u_dut2.acc_q), 32'(e));
    endtask

    task automatic chk_ptr(input string tag, input logic [IDW-1:0] e);
        chk({tag, "/m0/ptr"}, 32'(u_dut0.ptr_q), 32'(e));
        chk({tag, "/m1/ptr"}, 32'(u_dut1.ptr_q), 32'(e));
        chk({tag, "/m2/ptr"}, 32'(u_dut2.ptr_q), 32'(e));
    endtask

    task automatic drive_beat(input int c, input logic [N-1:0] d, input logic l);
        req_valid[c]       = 1'b1;
        req_data[c*N +: N] = d;
        req_last[c]        = l;
    endtask

    task automatic drop(input int c);
        req_valid[c] = 1'b0;
        req_last[c]  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Queue a frame of nb random beats for client c; par is 1 when the frame has even ones.
    task automatic add_frame(input int c, input int nb, output bit par);
        int ones;
        logic [N-1:0] d;
        ones = 0;
        for (int b = 0; b < nb; b++) begin
            d = N'($urandom);
            ones += $countones(d);
            bq[c].push_back('{data: d, last: (b == nb - 1)});
        end
        par = (ones % 2 == 0);
    endtask

    // Expected response order: round robin over clients that still hold frames.
    task automatic build_exp();
        bit any;
        bit done;
        int c;
        any = 1'b1;
        while (any) begin
            any  = 1'b0;
            done = 1'b0;
            for (int i = 0; i < R; i++) begin
                c = (ptr_m + i) % R;
                if (!done && fpar[c].size() > 0) begin
                    exp_q.push_back('{id: IDW'(c), par: fpar[c].pop_front()});
                    ptr_m = (c + 1) % R;
                    done  = 1'b1;
                    any   = 1'b1;
                end
            end
        end
    endtask

    // Clients present queued beats (bubbles only mid-frame); responses checked against exp_q.
    task automatic run_engine(input int budget, input int bub_pct, input int rdy_pct);
        bit    accf [R];
        bit    infr [R];
        beat_t tmp;
        rsp_t  e;
        int    n;
        for (int c = 0; c < R; c++) begin
            accf[c] = 1'b0;
            infr[c] = 1'b0;
        end
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            for (int c = 0; c < R; c++) begin
                if (accf[c]) begin
                    tmp     = bq[c].pop_front();
                    infr[c] = !tmp.last;
                end
            end
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("onehot/m%0d", m), 32'($countones(o_rdy[m]) <= 1), 32'(1));
            end
            rsp_ready = (int'($urandom_range(99)) < rdy_pct);
            if (o_rv[0] && rsp_ready) begin
                e = exp_q.pop_front();
                for (int m = 0; m < 3; m++) begin
                    chk($sformatf("rsp/m%0d/valid", m), 32'(o_rv[m]), 32'(1));
                    chk($sformatf("rsp/m%0d/id", m), 32'(o_id[m]), 32'(e.id));
                    chk($sformatf("rsp/m%0d/data", m), 32'(o_rd[m]), 32'(e.par));
                end
            end
            for (int c = 0; c < R; c++) begin
                if (bq[c].size() > 0 && !(infr[c] && int'($urandom_range(99)) < bub_pct)) begin
                    drive_beat(c, bq[c][0].data, bq[c][0].last);
                end else begin
                    drop(c);
                end
                accf[c] = o_rdy[0][c] && req_valid[c];
            end
        end
        chk("engine_drained", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        for (int c = 0; c < R; c++) begin
            bq[c].delete();
            fpar[c].delete();
            drop(c);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("engine_idle/m%0d", m), 32'(o_bz[m]), 32'(0));
        end
    endtask

    initial begin
        bit p;
        n_assert  = 0;
        n_fail    = 0;
        ptr_m     = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk_ptr("reset", 2'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("idle0", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

        // Single beat 8'h00 from requester 0
        drive_beat(0, 8'h00, 1'b1);
        @(negedge clk);
        chk_all("a_gnt", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drop(0);
        chk_all("a_rsp", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk_all("a_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Multi-beat frame with a two-cycle bubble from requester 1
        drive_beat(1, 8'h01, 1'b0);
        @(negedge clk);
        chk_all("b_gnt", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk_acc("b_acc0", 1'b0);
        @(negedge clk);
        chk_acc("b_acc1", 1'b1);
        drive_beat(1, 8'h03, 1'b0);
        @(negedge clk);
        chk_acc("b_acc2", 1'b1);
        drop(1);
        @(negedge clk);
        chk_all("b_bub1", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk_acc("b_bub1", 1'b1);
        @(negedge clk);
        chk_all("b_bub2", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk_acc("b_bub2", 1'b1);
        drive_beat(1, 8'h80, 1'b1);
        @(negedge clk);
        drop(1);
        chk_all("b_rsp", 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk_all("b_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        drive_beat(1, 8'h07, 1'b1);
        @(negedge clk);
        chk_all("b2_gnt", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drop(1);
        chk_all("b2_rsp", 4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk_all("b2_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Round robin: all four requesters, expected ids 0,1,2,3
        pulse_reset();
        for (int c = 0; c < R; c++) begin
            add_frame(c, 1, p);
            exp_q.push_back('{id: IDW'(c), par: p});
        end
        run_engine(200, 0, 100);
        chk_ptr("c_wrap", 2'd0);
        add_frame(2, 1, p);
        add_frame(0, 1, p);
        exp_q.delete();
        bq[0][0].data = 8'h0F;
        bq[2][0].data = 8'h01;
        exp_q.push_back('{id: 2'd0, par: 1'b1});
        exp_q.push_back('{id: 2'd2, par: 1'b0});
        run_engine(200, 0, 100);

        // Response backpressure; requester 1 raises valid during the stall
        rsp_ready = 1'b0;
        drive_beat(2, 8'h5A, 1'b1);
        @(negedge clk);
        chk_all("d_gnt", 4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drop(2);
        chk_all("d_rsp", 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
        drive_beat(1, 8'h70, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all($sformatf("d_hold%0d", i), 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk_all("d_idle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("d_gnt1", 4'b0010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drop(1);
        chk_all("d_rsp1", 4'b0000, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        chk_all("d_idle1", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of requester 3's frame
        drive_beat(3, 8'h12, 1'b0);
        @(negedge clk);
        chk_all("e_gnt", 4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drive_beat(3, 8'h34, 1'b0);
        @(negedge clk);
        chk_all("e_mid", 4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        drop(3);
        #1;
        chk_all("e_rst", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk_ptr("e_rst", 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(0, 8'hFF, 1'b1);
        @(negedge clk);
        chk_all("e_gnt0", 4'b0001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        drop(0);
        chk_all("e_rsp0", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("e_quiet%0d", i), 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        end

        // Randomized frames, bubbles and response backpressure
        pulse_reset();
        ptr_m = 0;
        for (int f = 0; f < 40; f++) begin
            int c;
            c = int'($urandom_range(R - 1));
            add_frame(c, int'($urandom_range(4, 1)), p);
            fpar[c].push_back(p);
        end
        build_exp();
        run_engine(4000, 25, 70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
